// File: rtl/add_seq_arbiter_if.sv
// Bundle of requester, shared-adder and response signals for add_seq_arbiter.
// master: the environment (requesters, adder, response consumer).
// slave:  the arbiter/sequencer itself.
interface add_seq_arbiter_if #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 2
);
  localparam int OPW = WORD_W * NWORDS;

  // Requester 0
  logic              req0_valid;
  logic              req0_ready;
  logic [OPW-1:0]    req0_op1;
  logic [OPW-1:0]    req0_op2;
  logic              req0_cin;

  // Requester 1
  logic              req1_valid;
  logic              req1_ready;
  logic [OPW-1:0]    req1_op1;
  logic [OPW-1:0]    req1_op2;
  logic              req1_cin;

  // Shared word adder
  logic [WORD_W-1:0] add_op1;
  logic [WORD_W-1:0] add_op2;
  logic              add_cin;
  logic [WORD_W-1:0] add_result;
  logic              add_cout;

  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [OPW-1:0]    rsp_result;
  logic              rsp_cout;
  logic              busy;

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_cin,
    input  req0_ready,
    output req1_valid, req1_op1, req1_op2, req1_cin,
    input  req1_ready,
    input  add_op1, add_op2, add_cin,
    output add_result, add_cout,
    input  rsp_valid, rsp_id, rsp_result, rsp_cout, busy,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_cin,
    output req0_ready,
    input  req1_valid, req1_op1, req1_op2, req1_cin,
    output req1_ready,
    output add_op1, add_op2, add_cin,
    input  add_result, add_cout,
    output rsp_valid, rsp_id, rsp_result, rsp_cout, busy,
    input  rsp_ready
  );
endinterface

// File: rtl/add_seq_arbiter.sv
// Round-robin arbiter sequencing one shared WORD_W adder over NWORDS-word additions.
// Latency: accept at T, adder words T+1..T+NWORDS, response valid from T+NWORDS+1.
// Backpressure: response held in DONE until rsp_ready; no request accepted outside IDLE.
module add_seq_arbiter #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 2
) (
  input logic             clk,
  input logic             reset,
  add_seq_arbiter_if.slave bus
);
  localparam int OPW = WORD_W * NWORDS;
  localparam int KW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic            last_grant_q;
  logic [KW-1:0]   k_q;
  logic            carry_q;
  logic [OPW-1:0]  op1_q;
  logic [OPW-1:0]  op2_q;
  logic            cin_q;
  logic            id_q;
  logic [OPW-1:0]  result_q;
  logic            rsp_valid_q;
  logic            rsp_cout_q;
  logic            busy_q;

  logic            gnt0;
  logic            gnt1;
  logic            take;
  logic [OPW-1:0]  sel_op1;
  logic [OPW-1:0]  sel_op2;
  logic            sel_cin;
  int unsigned     base;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    gnt0    = bus.req0_valid & (~bus.req1_valid | last_grant_q);
    gnt1    = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    take    = (state_q == IDLE) & ~reset & (gnt0 | gnt1);
    sel_op1 = gnt1 ? bus.req1_op1 : bus.req0_op1;
    sel_op2 = gnt1 ? bus.req1_op2 : bus.req0_op2;
    sel_cin = gnt1 ? bus.req1_cin : bus.req0_cin;
    base    = int'(k_q) * WORD_W;
  end

  // Ready only in IDLE and only for the winner; held low while reset is asserted
  assign bus.req0_ready = (state_q == IDLE) & ~reset & gnt0;
  assign bus.req1_ready = (state_q == IDLE) & ~reset & gnt1;

  // Feed word k of the captured operands to the shared adder; quiet outside RUN
  always_comb begin
    bus.add_op1 = '0;
    bus.add_op2 = '0;
    bus.add_cin = 1'b0;
    if (state_q == RUN) begin
      bus.add_op1 = op1_q[base +: WORD_W];
      bus.add_op2 = op2_q[base +: WORD_W];
      bus.add_cin = (k_q == '0) ? cin_q : carry_q;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_cout   = rsp_cout_q;
  assign bus.busy       = busy_q;

  // Sequencer FSM: capture on handshake, one adder word per cycle, hold result until taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      k_q          <= '0;
      carry_q      <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      cin_q        <= 1'b0;
      id_q         <= 1'b0;
      result_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_cout_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take) begin
            op1_q        <= sel_op1;
            op2_q        <= sel_op2;
            cin_q        <= sel_cin;
            id_q         <= gnt1;
            last_grant_q <= gnt1;
            k_q          <= '0;
            busy_q       <= 1'b1;
            state_q      <= RUN;
          end
        end
        RUN: begin
          result_q[base +: WORD_W] <= bus.add_result;
          carry_q                  <= bus.add_cout;
          k_q                      <= k_q + KW'(1);
          if (k_q == KW'(NWORDS - 1)) begin
            rsp_cout_q  <= bus.add_cout;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
